ppu_ctrl_pipe: RTL



---
 rtl/ppu_ctrl_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/ppu_ctrl_pipe.sv
// rtl/ppu_ctrl_pipe.sv - PPU control-word pipeline ID/EX -> EX/MEM -> MEM/WB
// with load-use stall detection and EX-stage forwarding selects.
module ppu_ctrl_pipe #(
   parameter int CTRL_W = 24,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              flush,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CTRL_W-1:0] wb_ctrl,
   output logic [REG_W-1:0]  ex_dest,
   output logic [REG_W-1:0]  mem_dest,
   output logic [REG_W-1:0]  wb_dest,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall
);

   localparam logic [REG_W-1:0] REG_ZERO = '0;
   localparam logic [REG_W-1:0] REG_LINK = '1;

   logic [REG_W-1:0] id_dest;
   logic             ex_is_load;
   logic             mem_wr;
   logic             wb_wr;

   always_comb begin
      id_dest = REG_ZERO;
      case (id_ctrl[19:18])
         2'b00: id_dest = REG_ZERO;
         2'b01: id_dest = id_rd;
         2'b10: id_dest = id_rt;
         2'b11: id_dest = REG_LINK;
         default: id_dest = REG_ZERO;
      endcase
   end

   // ADDIU also sets Load_Instr; only a memory-enabled one is a real load.
   assign ex_is_load = ex_ctrl[9] & ex_ctrl[2];

   assign stall = ex_is_load & ex_ctrl[8] & (ex_dest != REG_ZERO) &
                  ((ex_dest == id_rs) | (ex_dest == id_rt));

   assign mem_wr = mem_ctrl[8] & (mem_dest != REG_ZERO);
   assign wb_wr  = wb_ctrl[8]  & (wb_dest  != REG_ZERO);

   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (mem_wr && mem_dest == ex_rs)
         fwd_a_sel = 2'b01;
      else if (wb_wr && wb_dest == ex_rs)
         fwd_a_sel = 2'b10;
      if (mem_wr && mem_dest == ex_rt)
         fwd_b_sel = 2'b01;
      else if (wb_wr && wb_dest == ex_rt)
         fwd_b_sel = 2'b10;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ctrl  <= '0;
         ex_dest  <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         mem_ctrl <= '0;
         mem_dest <= '0;
         wb_ctrl  <= '0;
         wb_dest  <= '0;
      end else begin
         if (flush || stall) begin
            ex_ctrl <= '0;
            ex_dest <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
         end else begin
            ex_ctrl <= id_ctrl;
            ex_dest <= id_dest;
            ex_rs   <= id_rs;
            ex_rt   <= id_rt;
         end
         mem_ctrl <= ex_ctrl;
         mem_dest <= ex_dest;
         wb_ctrl  <= mem_ctrl;
         wb_dest  <= mem_dest;
      end
   end

endmodule
